reg_writeback_queue: RTL and testbench

Writer-side companion to the 32x32 register bench. It buffers register write-back requests from the ALU and load/memory paths and drains them one per cycle into the bench's single write port (write address, write data, write enable). A lookup port lets decode forward values still waiting in the queue. It sits between the execute/memory stages and the register bench.

---
 rtl/reg_wb_pkg.sv | 16 +
 rtl/reg_wb_fifo.sv | 79 +++++++
 rtl/reg_writeback_queue.sv | 110 +++++++++++
 tb/tb_reg_writeback_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register write-back queue: default widths,
// reserved register numbers and the queued entry layout.
package reg_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_CONST = 5'd1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addy;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// Entry storage for the write-back queue: circular buffer with head/tail
// pointers, occupancy count and an in-place overwrite of the youngest entry.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       overwrite_tail,
  input  logic [ADDR_W-1:0]          push_addy,
  input  logic [DATA_W-1:0]          push_data,
  output logic [$clog2(DEPTH)-1:0]   head_ptr,
  output logic [ADDR_W-1:0]          tail_addy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [ADDR_W-1:0]          entry_addy [DEPTH],
  output logic [DATA_W-1:0]          entry_data [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] addy_q [DEPTH];
  logic [ADDR_W-1:0] addy_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  tail_last;
  logic [CNT_W-1:0]  count_q, count_d;

  // Youngest entry sits one slot behind the tail pointer.
  assign tail_last = tail_q - PTR_W'(1);

  always_comb begin
    addy_d  = addy_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      addy_d[tail_q] = push_addy;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + PTR_W'(1);
    end else if (overwrite_tail) begin
      data_d[tail_last] = push_data;
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addy_q  <= '{default: '0};
      data_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addy_q  <= addy_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_ptr   = head_q;
  assign tail_addy  = addy_q[tail_last];
  assign count      = count_q;
  assign entry_addy = addy_q;
  assign entry_data = data_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-back queue between execute/memory and the register bench write port.
// Define REG_WB_COALESCE_EN to merge a push into a matching youngest entry.
module reg_writeback_queue
  import reg_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_addy,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_addy,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  input  logic                       wb_stall,
  output logic [ADDR_W-1:0]          wb_writeAddy,
  output logic [DATA_W-1:0]          wb_writeData,
  output logic                       wb_regWrite,
  input  logic [ADDR_W-1:0]          fwd_addy,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

`ifdef REG_WB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic              mem_fire, alu_fire, push_any, push_ok;
  logic              in_reserved, fwd_reserved;
  logic              pop, coalesce_hit, do_overwrite, do_alloc;
  logic [ADDR_W-1:0] in_addy;
  logic [DATA_W-1:0] in_data;
  logic [PTR_W-1:0]  head_ptr, fwd_idx;
  logic [ADDR_W-1:0] tail_addy;
  logic [ADDR_W-1:0] entry_addy [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign mem_fire = mem_valid && mem_ready;
  assign alu_fire = alu_valid && alu_ready;
  assign push_any = mem_fire || alu_fire;
  assign in_addy  = mem_fire ? mem_addy : alu_addy;
  assign in_data  = mem_fire ? mem_data : alu_data;

  assign in_reserved  = (in_addy == ADDR_W'(REG_ZERO)) || (in_addy == ADDR_W'(REG_CONST));
  assign fwd_reserved = (fwd_addy == ADDR_W'(REG_ZERO)) || (fwd_addy == ADDR_W'(REG_CONST));
  assign push_ok      = push_any && !in_reserved;

  // The write happens on the same edge that retires the head.
  assign pop          = !empty && !wb_stall;
  assign wb_regWrite  = pop;
  assign wb_writeAddy = empty ? '0 : entry_addy[head_ptr];
  assign wb_writeData = empty ? '0 : entry_data[head_ptr];

  // A lone entry leaving this cycle cannot absorb the new value.
  assign coalesce_hit = !empty && (tail_addy == in_addy) && !(pop && count == CNT_W'(1));
  assign do_overwrite = COALESCE && push_ok && coalesce_hit;
  assign do_alloc     = push_ok && !do_overwrite;

  reg_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (do_alloc),
    .pop            (pop),
    .overwrite_tail (do_overwrite),
    .push_addy      (in_addy),
    .push_data      (in_data),
    .head_ptr       (head_ptr),
    .tail_addy      (tail_addy),
    .count          (count),
    .entry_addy     (entry_addy),
    .entry_data     (entry_data)
  );

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entry_addy[fwd_idx] == fwd_addy) && !fwd_reserved) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed and randomized bench for reg_writeback_queue against a queue-based
// reference model of the write-back rules.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, wb_stall;
  logic [4:0]  alu_addy, mem_addy, fwd_addy;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, wb_regWrite, fwd_hit, full, empty;
  logic [4:0]  wb_writeAddy;
  logic [31:0] wb_writeData, fwd_data;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_addy     (alu_addy),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_addy     (mem_addy),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .wb_stall     (wb_stall),
    .wb_writeAddy (wb_writeAddy),
    .wb_writeData (wb_writeData),
    .wb_regWrite  (wb_regWrite),
    .fwd_addy     (fwd_addy),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from the reference queue contents.
  task automatic check_model();
    int          n   = q.size();
    logic        hit = 1'b0;
    logic [31:0] fd  = 32'h0;
    if (fwd_addy > 5'd1) begin
      foreach (q[i]) begin
        if (q[i].a == fwd_addy) begin
          hit = 1'b1;
          fd  = q[i].d;
        end
      end
    end
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("mem_ready", 32'(mem_ready), 32'(n != DEPTH));
    chk("alu_ready", 32'(alu_ready), 32'((n != DEPTH) && !mem_valid));
    chk("wb_regWrite", 32'(wb_regWrite), 32'((n > 0) && !wb_stall));
    chk("wb_writeAddy", 32'(wb_writeAddy), (n > 0) ? 32'(q[0].a) : 32'h0);
    chk("wb_writeData", wb_writeData, (n > 0) ? q[0].d : 32'h0);
    chk("fwd_hit", 32'(fwd_hit), 32'(hit));
    chk("fwd_data", fwd_data, fd);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic st, input logic [4:0] fa);
    @(negedge clock);
    alu_valid = av; alu_addy = aa; alu_data = ad;
    mem_valid = mv; mem_addy = ma; mem_data = md;
    wb_stall  = st; fwd_addy = fa;
    #1;
  endtask

  // Advance the reference model across one rising edge.
  task automatic tick();
    int          n;
    logic        pop, fire_m, fire_a, push, merged;
    logic [4:0]  pa;
    logic [31:0] pd;
    ent_t        e;
    @(posedge clock);
    n      = q.size();
    pop    = (n > 0) && !wb_stall;
    fire_m = mem_valid && (n != DEPTH);
    fire_a = alu_valid && (n != DEPTH) && !mem_valid;
    pa     = fire_m ? mem_addy : alu_addy;
    pd     = fire_m ? mem_data : alu_data;
    push   = (fire_m || fire_a) && (pa > 5'd1);
    merged = 1'b0;
`ifdef REG_WB_COALESCE_EN
    if (push && n > 0 && q[n-1].a == pa && !(pop && n == 1)) begin
      e = q[n-1];
      e.d = pd;
      q[n-1] = e;
      merged = 1'b1;
    end
`endif
    if (pop) void'(q.pop_front());
    if (push && !merged) begin
      e.a = pa;
      e.d = pd;
      q.push_back(e);
    end
  endtask

  task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic st, input logic [4:0] fa);
    drive(av, aa, ad, mv, ma, md, st, fa);
    check_model();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_addy = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addy = '0; mem_data = '0;
    wb_stall = 1'b0; fwd_addy = '0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_we", 32'(wb_regWrite), 32'd0);
    chk("rst_addy", 32'(wb_writeAddy), 32'd0);
    chk("rst_data", wb_writeData, 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Single ALU push, one cycle to the bench write.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_model();
    chk("t1_we", 32'(wb_regWrite), 32'd1);
    chk("t1_addy", 32'(wb_writeAddy), 32'd5);
    chk("t1_data", wb_writeData, 32'hDEADBEEF);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_model();
    chk("t1_empty", 32'(empty), 32'd1);
    tick();

    // Load wins arbitration; ALU retried next cycle.
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    check_model();
    chk("t2_alu_ready", 32'(alu_ready), 32'd0);
    chk("t2_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_model();
    chk("t2_first_addy", 32'(wb_writeAddy), 32'd4);
    chk("t2_first_data", wb_writeData, 32'h22);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_model();
    chk("t2_second_addy", 32'(wb_writeAddy), 32'd3);
    chk("t2_second_data", wb_writeData, 32'h11);
    tick();
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    // Fill under stall, then drain in order.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'(2 + i), 32'(32'h100 + i), 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h67, 1'b1, 5'd0);
    check_model();
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_alu_ready", 32'(alu_ready), 32'd0);
    chk("t3_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      check_model();
      chk("t3_drain_we", 32'(wb_regWrite), 32'd1);
      chk("t3_drain_addy", 32'(wb_writeAddy), 32'(2 + i));
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_model();
    chk("t3_empty", 32'(empty), 32'd1);
    tick();

    // Reserved registers are accepted and dropped.
    cyc(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h7, 1'b0, 5'd0);
    check_model();
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_we", 32'(wb_regWrite), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_model();
    chk("t4_count_after", 32'(count), 32'd0);
    chk("t4_we_after", 32'(wb_regWrite), 32'd0);
    tick();

    // Forwarding picks the youngest of two same-register entries.
    cyc(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    cyc(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    check_model();
    chk("t5_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("t5_fwd_data", fwd_data, 32'hB);
`ifdef REG_WB_COALESCE_EN
    chk("t5_count", 32'(count), 32'd1);
`else
    chk("t5_count", 32'(count), 32'd2);
`endif
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
    check_model();
    chk("t5_fwd_miss", 32'(fwd_hit), 32'd0);
    tick();
    repeat (3) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7);

    // Asynchronous reset with entries pending.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'(2 + i), 32'(32'h200 + i), 1'b1, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3);
    check_model();
    #1 reset = 1'b1;
    #1;
    chk("t6_we", 32'(wb_regWrite), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_fwd_hit", 32'(fwd_hit), 32'd0);
    q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3);

    // Randomized traffic with collisions, reserved targets and stalls.
    repeat (400) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 8)));
    end
    repeat (6) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
